// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among four
// byte sources. A granted source keeps the transmitter until its last byte.
// Optional stall eviction: define UART_ARB_TIMEOUT_EN to enable the
// TIMEOUT-based watchdog and the err pulse.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  input  logic [3:0]  last,
  input  logic        tx_rdy,
  output logic [3:0]  ack,
  output logic        load,
  output logic [7:0]  out_port,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        err
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LOW,
    S_WAIT_RDY
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                lst_q, lst_d;
  logic [BYTE_W-1:0]   out_port_q, out_port_d;
  logic                load_q, load_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                busy_q, busy_d;

  logic [ID_W-1:0]     pick;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [BYTE_W-1:0]   sel_byte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sent_q, sent_d;
  logic                err_q, err_d;
`else
  logic                unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // Byte currently offered by the granted requester
  assign sel_byte = data[{grant_id_q, 3'b000} +: BYTE_W];

  // Round-robin search: first requester at or after ptr, modulo 4
  always_comb begin
    pick       = ptr_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pick_idx = ptr_q + ID_W'(i);
      if (!pick_found && req[pick_idx]) begin
        pick       = pick_idx;
        pick_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    lst_d      = lst_q;
    out_port_d = out_port_q;
    load_d     = 1'b0;
    ack_d      = '0;
`ifdef UART_ARB_TIMEOUT_EN
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    sent_d     = sent_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (tx_rdy && pick_found) begin
          grant_id_d = pick;
          state_d    = S_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d      = '0;
          sent_d     = 1'b0;
`endif
        end
      end

      S_LOAD: begin
        if (req[grant_id_q]) begin
          load_d     = 1'b1;
          ack_d      = 4'b0001 << grant_id_q;
          out_port_d = sel_byte;
          lst_d      = last[grant_id_q];
          state_d    = S_WAIT_LOW;
`ifdef UART_ARB_TIMEOUT_EN
          sent_d     = 1'b1;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Stalled mid-message: evict once the budget is spent
        else if (sent_q) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            ptr_d   = grant_id_q + 2'd1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end

      S_WAIT_LOW: begin
        if (!tx_rdy) begin
          state_d = S_WAIT_RDY;
        end
      end

      S_WAIT_RDY: begin
        if (tx_rdy) begin
          if (lst_q) begin
            ptr_d   = grant_id_q + 2'd1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      ptr_q      <= '0;
      lst_q      <= 1'b0;
      out_port_q <= '0;
      load_q     <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      lst_q      <= lst_d;
      out_port_q <= out_port_d;
      load_q     <= load_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Stall watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      sent_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sent_q <= sent_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ack      = ack_q;
  assign load     = load_q;
  assign out_port = out_port_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule
